// File: rtl/simon_player_if.sv
// rtl/simon_player_if.sv - control, sequence-memory and LED/tone signals of the Simon playback block
interface simon_player_if #(
  parameter int AW = 5
);
  logic          start;
  logic          abort;
  logic [AW-1:0] length;
  logic [3:0]    speed;
  logic [AW-1:0] seq_addr;
  logic [1:0]    seq_color;
  logic [3:0]    led;
  logic          tone_en;
  logic          busy;
  logic          done;

  // game controller / memory side
  modport master (
    output start, abort, length, speed, seq_color,
    input  seq_addr, led, tone_en, busy, done
  );

  // playback engine side
  modport slave (
    input  start, abort, length, speed, seq_color,
    output seq_addr, led, tone_en, busy, done
  );
endinterface

// File: rtl/simon_player.sv
// rtl/simon_player.sv - plays a stored Simon colour sequence with speed-scaled on-time and fixed dark gap
module simon_player #(
  parameter int BASE_ON   = 24000000,
  parameter int STEP_ON   = 2000000,
  parameter int MIN_ON    = 4800000,
  parameter int GAP_TICKS = 4800000,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  simon_player_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ON, S_GAP, S_DONE} state_t;

  localparam logic [31:0] BASE_L = 32'(BASE_ON);
  localparam logic [31:0] STEP_L = 32'(STEP_ON);
  localparam logic [31:0] MIN_L  = 32'(MIN_ON);
  localparam logic [31:0] GAP_L  = 32'(GAP_TICKS);

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] len_q, len_n;
  logic [3:0]    speed_q, speed_n;
  logic [1:0]    color, color_n;
  logic [31:0]   cnt, cnt_n;
  logic [31:0]   step_prod, on_diff, on_ticks;

  // on-time from the latched speed; clamps both underflow and anything below the floor
  always_comb begin
    step_prod = STEP_L * {28'd0, speed_q};
    on_diff   = BASE_L - step_prod;
    on_ticks  = on_diff;
    if ((step_prod > BASE_L) || (on_diff < MIN_L)) begin
      on_ticks = MIN_L;
    end
  end

  // state and datapath registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      len_q   <= '0;
      speed_q <= '0;
      color   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      len_q   <= len_n;
      speed_q <= speed_n;
      color   <= color_n;
      cnt     <= cnt_n;
    end
  end

  // next-state and datapath updates; abort overrides any phase transition
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    speed_n = speed_q;
    color_n = color;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.length != '0) begin
            len_n   = bus.length;
            speed_n = bus.speed;
            idx_n   = '0;
            state_n = S_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_LOAD: begin
        color_n = bus.seq_color;
        cnt_n   = '0;
        state_n = S_ON;
      end
      S_ON: begin
        if (cnt == on_ticks - 32'd1) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_L - 32'd1) begin
          cnt_n = '0;
          if (idx == len_q - AW'(1)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + AW'(1);
            state_n = S_LOAD;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (bus.abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end
  end

  // outputs decode only registered state so they never glitch from inputs
  assign bus.seq_addr = idx;
  assign bus.led      = (state == S_ON) ? (4'b0001 << color) : 4'b0000;
  assign bus.tone_en  = (state == S_ON);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
endmodule

// File: tb/tb_simon_player.sv
// tb/tb_simon_player.sv - scoreboard bench for simon_player playback, speed, abort and reset behaviour
module tb_simon_player;
  localparam int BASE_ON = 20;
  localparam int STEP_ON = 4;
  localparam int MIN_ON  = 6;
  localparam int GAP     = 5;
  localparam int AW      = 5;

  typedef struct {
    logic [3:0] led;
    int         len;
  } run_t;

  logic clk;
  logic reset;
  logic [1:0] mem [0:31];
  run_t exp_q[$];
  int errors = 0;
  int checks = 0;

  simon_player_if #(.AW(AW)) bus ();

  simon_player #(
    .BASE_ON(BASE_ON), .STEP_ON(STEP_ON), .MIN_ON(MIN_ON), .GAP_TICKS(GAP), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  assign bus.seq_color = mem[bus.seq_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int on_model(input int spd);
    int p;
    p = STEP_ON * spd;
    if (p > BASE_ON || BASE_ON - p < MIN_ON) return MIN_ON;
    return BASE_ON - p;
  endfunction

  // ab_step/ab_cyc: abort on the ab_cyc-th lit cycle of step ab_step (-1 = none)
  // bst: cycle after start at which a second start (length 1) is driven (-1 = none)
  task automatic play(input int n, input int spd, input int ab_step, input int ab_cyc,
                      input int bst, input string tag);
    int ont, exp_busy, busy_cnt, done_cnt, tone_bad, addr_bad, done_bad;
    int run_len, run_idx;
    logic [3:0] run_led;
    bit in_run, seen, fin, aborted;
    run_t r, e;
    ont = on_model(spd);
    busy_cnt = 0; done_cnt = 0; tone_bad = 0; addr_bad = 0; done_bad = 0;
    run_len = 0; run_idx = -1; run_led = 4'b0;
    in_run = 0; seen = 0; fin = 0; aborted = 0;
    for (int i = 0; i < n; i++) begin
      if (ab_step >= 0 && i > ab_step) break;
      r.led = 4'b0001 << mem[i];
      r.len = (i == ab_step) ? ab_cyc : ont;
      exp_q.push_back(r);
    end
    if (ab_step >= 0) exp_busy = ab_step * (1 + ont + GAP) + 1 + ab_cyc;
    else exp_busy = n * (1 + ont + GAP) + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.length = AW'(n); bus.speed = 4'(spd);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == bst);
      if (cyc == bst) bus.length = AW'(1);
      bus.abort = 1'b0;
      if (bus.busy) begin seen = 1; busy_cnt++; end
      if (bus.done) begin
        done_cnt++;
        if (!bus.busy) done_bad++;
      end
      if (bus.tone_en !== (bus.led != 4'b0)) tone_bad++;
      if (bus.led != 4'b0) begin
        if (!(in_run && bus.led == run_led)) begin
          in_run = 1; run_led = bus.led; run_len = 0; run_idx++;
        end
        run_len++;
        if (bus.seq_addr !== AW'(run_idx)) addr_bad++;
        if (run_idx == ab_step && run_len == ab_cyc) begin
          bus.abort = 1'b1; aborted = 1;
        end
      end else if (in_run) begin
        in_run = 0;
        if (exp_q.size() == 0) chk({tag, " extra_run"}, 32'(run_len), 0);
        else begin
          e = exp_q.pop_front();
          chk({tag, " run_led"}, 32'(run_led), 32'(e.led));
          chk({tag, " run_len"}, 32'(run_len), 32'(e.len));
        end
      end
      if (seen && !bus.busy) begin fin = 1; break; end
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    chk({tag, " finished"}, 32'(fin), 1);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, " done_pulses"}, 32'(done_cnt), aborted ? 0 : 1);
    chk({tag, " done_outside_busy"}, 32'(done_bad), 0);
    chk({tag, " tone_mismatch"}, 32'(tone_bad), 0);
    chk({tag, " addr_mismatch"}, 32'(addr_bad), 0);
    chk({tag, " runs_left"}, 32'(exp_q.size()), 0);
    if (aborted) begin
      chk({tag, " abort_led"}, 32'(bus.led), 0);
      chk({tag, " abort_addr"}, 32'(bus.seq_addr), 0);
    end
    exp_q.delete();
  endtask

  task automatic wait_led(input bit lit, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((bus.led != 4'b0) == lit) begin ok = 1; break; end
    end
    if (!ok) chk({tag, " wait_timeout"}, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.length = '0; bus.speed = '0;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(bus.led), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_tone", 32'(bus.tone_en), 0);
    chk("reset_addr", 32'(bus.seq_addr), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    // basic playback
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(3, 0, -1, -1, -1, "basic");

    // speed scaling with a single colour-1 step
    mem[0] = 2'd1;
    play(1, 2, -1, -1, -1, "spd2");
    play(1, 3, -1, -1, -1, "spd3");
    play(1, 4, -1, -1, -1, "spd4");
    play(1, 15, -1, -1, -1, "spd15");

    // zero length
    play(0, 0, -1, -1, -1, "zero");

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.length = AW'(2);
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_idle_busy", 32'(bus.busy), 0);

    // abort on 10th ON cycle of step 2, then full replay
    mem[0] = 2'd3; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd0;
    play(4, 0, 1, 10, -1, "abort");
    play(4, 0, -1, -1, -1, "replay");

    // start while busy is ignored
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(3, 0, -1, -1, 5, "busy_start");

    // maximum length with random colours
    for (int i = 0; i < 31; i++) mem[i] = 2'($urandom_range(0, 3));
    play(31, 1, -1, -1, -1, "maxlen");

    // async reset mid-GAP of step 2
    mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3;
    @(negedge clk);
    bus.start = 1'b1; bus.length = AW'(3); bus.speed = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_led(1, "rst_gap_on1");
    wait_led(0, "rst_gap_gap1");
    wait_led(1, "rst_gap_on2");
    wait_led(0, "rst_gap_gap2");
    chk("rst_gap_pre_addr", 32'(bus.seq_addr), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_gap_busy", 32'(bus.busy), 0);
    chk("rst_gap_led", 32'(bus.led), 0);
    chk("rst_gap_addr", 32'(bus.seq_addr), 0);
    @(negedge clk);
    reset = 1'b1;

    // async reset mid-ON drops the LED without a clock edge
    @(negedge clk);
    bus.start = 1'b1; bus.length = AW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_led(1, "rst_on_lit");
    repeat (4) @(negedge clk);
    chk("rst_on_pre_led", 32'(bus.led), 32'(4'b0010));
    #2 reset = 1'b0;
    #1;
    chk("rst_on_led", 32'(bus.led), 0);
    chk("rst_on_tone", 32'(bus.tone_en), 0);
    chk("rst_on_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;

    play(3, 0, -1, -1, -1, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simon_player.md
Name: simon_player

Overview:
- Plays back a stored Simon colour sequence. For each step it lights one of four LEDs, with a tone, for a speed-dependent on-time, then holds a dark gap.
- Owns its own tick counter: restarts it per phase and consumes its own expiry, the consumer side of the game's timing pulses.
- Sits between the sequence memory and the LED/tone drivers; the game controller starts it once per round.

Parameters:
- BASE_ON, 24000000, on-time in clk cycles at speed 0
- STEP_ON, 2000000, on-time reduction per speed unit
- MIN_ON, 4800000, floor for the on-time
- GAP_TICKS, 4800000, dark gap after each colour, in clk cycles
- AW, 5, sequence address width; max length 2^AW-1

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low: 0 clears all state immediately, release synchronous to clk
- start  input  1  single-cycle request to play; sampled in IDLE only
- abort  input  1  stop playback, return to IDLE
- length  input  AW  number of steps to play, latched on start
- speed  input  4  speed index 0..15, latched on start
- seq_addr  output  AW  sequence memory read address (= current index)
- seq_color  input  2  colour at seq_addr; combinational memory, valid same cycle
- led  output  4  one-hot lit LED (bit = colour), 0 when dark
- tone_en  output  1  high exactly while led != 0
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a full sequence has played

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, counter=0, len/speed regs=0; led=0, tone_en=0, busy=0, done=0, seq_addr=0.
- States: IDLE, LOAD, ON, GAP, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - start=1 and length!=0: latch length and speed, idx=0, go to LOAD.
  - start=1 and length==0: go straight to DONE; no LED activity.
  - Otherwise hold.
- LOAD (1 cycle): seq_addr=idx, capture seq_color into color reg, counter=0, go to ON.
- ON: led=onehot(color), tone_en=1. Counter increments each cycle. After exactly on_ticks cycles in ON, counter=0 and go to GAP.
- GAP: led=0. After exactly GAP_TICKS cycles, go to DONE if idx==len-1; else idx=idx+1 and go to LOAD.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- on_ticks arithmetic:
  - Computed from latched speed as 32-bit unsigned: BASE_ON - STEP_ON*speed.
  - If STEP_ON*speed > BASE_ON (underflow), or the result < MIN_ON, on_ticks = MIN_ON.
  - Constant for the whole playback.
- Timing: cycles per step = 1 + on_ticks + GAP_TICKS. Total busy cycles = len*(1+on_ticks+GAP_TICKS) + 1.
- seq_addr equals idx in every state; memory latency must be zero.
- start while busy: ignored; latched length/speed unchanged.
- abort: in any non-IDLE state, next edge goes to IDLE with led=0 and idx=0; no done pulse. Abort has priority over every phase transition.
- abort and start together in IDLE: abort wins, stay IDLE.
- length=2^AW-1: plays all steps; idx never wraps.
- reset mid-ON: led drops to 0 asynchronously, without waiting for a clock edge.

Test Plan:
(bench parameters: BASE_ON=20, STEP_ON=4, MIN_ON=6, GAP_TICKS=5, AW=5)
- Basic playback: memory {2,0,3}, length=3, speed=0, start pulse.
  - led=0100 for 20 cycles, 0 for 5; then 0001 20/5; then 1000 20/5.
  - tone_en mirrors led!=0; done high for exactly 1 cycle.
  - busy high for 79 cycles.
- Speed scaling, length=1, colour 1:
  - speed=2 -> led=0010 for 12 cycles.
  - speed=3 -> 8 cycles.
  - speed=4 -> 6 cycles (20-16=4, clamped to MIN_ON).
  - speed=15 -> 6 cycles (underflow clamped).
- Zero length: start with length=0 -> done pulse 2 edges after start, busy high 1 cycle, led stays 0.
- Abort: length=4, abort asserted on the 10th ON cycle of step 2 -> next edge IDLE, led=0, busy=0, no done. A following start replays from seq_addr=0.
- Async reset: reset driven low mid-GAP, between clock edges -> busy, led and seq_addr are 0 immediately. After release, the next start plays normally.
- Busy start ignored: second start with length=1 during step 1 of a length-3 run -> all 3 steps still play, a single done pulse.
